// File: rtl/dqpsk_symbol_mapper.sv
// DQPSK transmit mapper. Each input byte is split into four dibits, MSB pair
// first. Each dibit is Gray-coded into a phase step, the phase accumulator
// advances by that step, and the matching QPSK point is emitted
// SAMPLES_PER_SYMBOL times as a {I,Q} word. When enabled, each frame opens
// with a phase-0 reference symbol.
module dqpsk_symbol_mapper #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 8,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLES_PER_SYMBOL     = 4,
  parameter int AMPLITUDE              = 23170,
  parameter int EMIT_PREAMBLE          = 1
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  output logic [3:0]                        m00_axis_tstrb
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, SEND} state_t;

  localparam logic [15:0] A_POS     = 16'(AMPLITUDE);
  localparam logic [15:0] A_NEG     = 16'(-AMPLITUDE);
  localparam logic [7:0]  SAMP_LAST = 8'(SAMPLES_PER_SYMBOL - 1);
  localparam bit          PRE_EN    = (EMIT_PREAMBLE != 0);

  state_t      state, state_n;
  logic [7:0]  byte_q, byte_n;
  logic        last_q, last_n;
  logic [1:0]  phase, phase_n;
  logic        frame_start, fs_n;
  logic [1:0]  dib, dib_n;
  logic [7:0]  samp, samp_n;
  logic        vld, vld_n;
  logic [31:0] data, data_n;
  logic        tlast, tlast_n;
  logic        out_hs, sym_end;

  // Gray-coded dibit to phase step: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gray_inc(input logic [1:0] d);
    case (d)
      2'b00:   gray_inc = 2'd0;
      2'b01:   gray_inc = 2'd1;
      2'b11:   gray_inc = 2'd2;
      default: gray_inc = 2'd3;
    endcase
  endfunction

  // Dibit 0 is the MSB pair, dibit 3 the LSB pair
  function automatic logic [1:0] dibit_sel(input logic [7:0] b, input logic [1:0] i);
    case (i)
      2'd0:    dibit_sel = b[7:6];
      2'd1:    dibit_sel = b[5:4];
      2'd2:    dibit_sel = b[3:2];
      default: dibit_sel = b[1:0];
    endcase
  endfunction

  // Constellation point for a phase index, packed as {I,Q}
  function automatic logic [31:0] point(input logic [1:0] p);
    case (p)
      2'd0:    point = {A_POS, A_POS};
      2'd1:    point = {A_NEG, A_POS};
      2'd2:    point = {A_NEG, A_NEG};
      default: point = {A_POS, A_NEG};
    endcase
  endfunction

  assign out_hs          = vld & m00_axis_tready;
  assign sym_end         = out_hs & (samp == SAMP_LAST);
  assign s00_axis_tready = (state == IDLE);
  assign m00_axis_tvalid = vld;
  assign m00_axis_tdata  = data;
  assign m00_axis_tlast  = tlast;
  assign m00_axis_tstrb  = 4'hF;

  // Next-state, phase accumulation and the registered output sample
  always_comb begin
    state_n = state;
    byte_n  = byte_q;
    last_n  = last_q;
    phase_n = phase;
    fs_n    = frame_start;
    dib_n   = dib;
    samp_n  = samp;
    vld_n   = vld;
    data_n  = data;
    tlast_n = 1'b0;
    case (state)
      IDLE: begin
        if (s00_axis_tvalid) begin
          byte_n = s00_axis_tdata[7:0];
          last_n = s00_axis_tlast;
          samp_n = '0;
          dib_n  = '0;
          vld_n  = 1'b1;
          if (frame_start && PRE_EN) begin
            state_n = PREAMBLE;
            phase_n = 2'd0;
            fs_n    = 1'b0;
          end else begin
            state_n = SEND;
            phase_n = phase + gray_inc(s00_axis_tdata[7:6]);
          end
          data_n = point(phase_n);
        end
      end
      PREAMBLE: begin
        if (sym_end) begin
          state_n = SEND;
          samp_n  = '0;
          dib_n   = '0;
          phase_n = phase + gray_inc(byte_q[7:6]);
          data_n  = point(phase_n);
        end else if (out_hs) begin
          samp_n = samp + 8'd1;
        end
      end
      SEND: begin
        if (sym_end) begin
          samp_n = '0;
          if (dib == 2'd3) begin
            state_n = IDLE;
            vld_n   = 1'b0;
            fs_n    = last_q;
          end else begin
            dib_n   = dib + 2'd1;
            phase_n = phase + gray_inc(dibit_sel(byte_q, dib_n));
            data_n  = point(phase_n);
          end
        end else if (out_hs) begin
          samp_n = samp + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // tlast marks the final sample of the last dibit of a frame-ending byte
    if (state_n == SEND && last_n && dib_n == 2'd3 && samp_n == SAMP_LAST)
      tlast_n = 1'b1;
  end

  // State and output registers
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state       <= IDLE;
      byte_q      <= '0;
      last_q      <= 1'b0;
      phase       <= 2'd0;
      frame_start <= 1'b1;
      dib         <= '0;
      samp        <= '0;
      vld         <= 1'b0;
      data        <= '0;
      tlast       <= 1'b0;
    end else begin
      state       <= state_n;
      byte_q      <= byte_n;
      last_q      <= last_n;
      phase       <= phase_n;
      frame_start <= fs_n;
      dib         <= dib_n;
      samp        <= samp_n;
      vld         <= vld_n;
      data        <= data_n;
      tlast       <= tlast_n;
    end
  end

endmodule

// File: tb/tb_dqpsk_symbol_mapper.sv
// Scoreboard bench for dqpsk_symbol_mapper (SPS=4, preamble on).
module tb_dqpsk_symbol_mapper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  m_tstrb;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  int          m_ph = 0;
  bit          m_fs = 1'b1;
  bit          rnd_mode = 1'b0;
  int          n_out = 0;
  int          n_last = 0;
  bit          prev_stall = 1'b0;
  logic [32:0] prev_word = '0;

  dqpsk_symbol_mapper dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tstrb  (m_tstrb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pt(input int p);
    case (p)
      0:       pt = 32'h5A825A82;
      1:       pt = 32'hA57E5A82;
      2:       pt = 32'hA57EA57E;
      default: pt = 32'h5A82A57E;
    endcase
  endfunction

  function automatic int ginc(input logic [1:0] d);
    case (d)
      2'b00:   ginc = 0;
      2'b01:   ginc = 1;
      2'b11:   ginc = 2;
      default: ginc = 3;
    endcase
  endfunction

  // Expected sample stream for one byte
  task automatic model_byte(input logic [7:0] b, input bit l);
    logic [1:0] d;
    if (m_fs) begin
      m_ph = 0;
      repeat (4) exp_q.push_back({1'b0, pt(0)});
    end
    for (int i = 0; i < 4; i++) begin
      d = b[7-2*i -: 2];
      m_ph = (m_ph + ginc(d)) % 4;
      for (int s = 0; s < 4; s++)
        exp_q.push_back({(l && i == 3 && s == 3), pt(m_ph)});
    end
    m_fs = l;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit l);
    int n;
    model_byte(b, l);
    @(posedge clk); #1;
    s_tvalid = 1'b1; s_tdata = b; s_tlast = l;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_tready) break;
    end
    chk("accept", {63'd0, s_tready}, 64'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("latency", {63'd0, m_tvalid}, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_vld", {63'd0, m_tvalid}, 64'd0);
  endtask

  // Output ready: always 1, or ~50% random in backpressure mode
  initial begin
    forever begin
      @(posedge clk); #1;
      m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: compare handshaken samples and stall stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && m_tvalid)
        chk("stall_hold", {31'd0, m_tlast, m_tdata}, {31'd0, prev_word});
      if (m_tvalid && m_tready) begin
        n_out++;
        if (m_tlast) n_last++;
        if (exp_q.size() == 0) chk("extra_sample", {31'd0, m_tlast, m_tdata}, 64'd0);
        else chk("sample", {31'd0, m_tlast, m_tdata}, {31'd0, exp_q.pop_front()});
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int cnt;
    // Reset state
    #12;
    chk("rst_tready", {63'd0, s_tready}, 64'd1);
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_tdata", {32'd0, m_tdata}, 64'd0);
    chk("tstrb", {60'd0, m_tstrb}, 64'hF);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_tvalid) cnt++;
    end
    chk("idle_vld", 64'(cnt), 64'd0);

    // All-zero byte: preamble plus four phase-0 symbols
    send_byte(8'h00, 1'b1);
    drain();
    // Dibits 00,01,10,11 -> phases 0,1,0,2
    send_byte(8'h1B, 1'b1);
    drain();
    // Same byte under random backpressure
    rnd_mode = 1'b1;
    send_byte(8'h1B, 1'b1);
    drain();
    rnd_mode = 1'b0;

    // Two two-byte frames; phase carries across bytes, preamble per frame
    n_last = 0;
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b1);
    drain();
    chk("tlast_count", 64'(n_last), 64'd2);

    // Async reset mid-symbol
    n_out = 0;
    send_byte(8'h1B, 1'b1);
    cnt = 0;
    while (n_out < 7 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_count", 64'(n_out), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {63'd0, m_tvalid}, 64'd0);
    chk("mid_rst_tready", {63'd0, s_tready}, 64'd1);
    exp_q.delete();
    m_fs = 1'b1;
    m_ph = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send_byte(8'h00, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
